shift_reverse_pipe: RTL and testbench

Parametrised, pipelined multifunction shift unit: logical/arithmetic shift, rotate and full bit-reverse on a WIDTH-bit operand, with valid/ready handshakes on both sides. It generalises the team's fixed 8-bit combinational reverse function into a registered datapath sitting between an operand source and the result consumer of the barrel-shifter lab design. Two-cycle latency, full throughput, lossless backpressure.

---
 rtl/shifter_pkg.sv | 21 ++
 rtl/shift_right_core.sv | 27 ++
 rtl/shift_reverse_pipe.sv | 151 +++++++++++++++
 tb/tb_shift_reverse_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared op-code definitions and decode helpers for the shift_reverse_pipe datapath.
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100,
    OP_REV = 3'b101
  } op_e;

  function automatic logic is_left(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_ROL);
  endfunction

  function automatic logic is_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/shift_right_core.sv
// Combinational log2(WIDTH)-level right shifter/rotator; vacated bits take 'fill' unless rotating.
module shift_right_core #(
  parameter  int WIDTH = 8,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  input  logic [SW-1:0]    sh,
  input  logic             rotate,
  input  logic             fill,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] lvl [SW+1];

  assign lvl[0] = din;

  for (genvar k = 0; k < SW; k++) begin : g_lvl
    localparam int N = 1 << k;
    logic [WIDTH-1:0] moved;
    assign moved    = rotate ? {lvl[k][N-1:0], lvl[k][WIDTH-1:N]}
                             : {{N{fill}}, lvl[k][WIDTH-1:N]};
    assign lvl[k+1] = sh[k] ? moved : lvl[k];
  end

  assign dout = lvl[SW];

endmodule

// File: rtl/shift_reverse_pipe.sv
// Two-stage valid/ready shift/rotate/reverse unit. Define SHIFT_CARRY_EN to add the co
// (last bit shifted out) port.
module shift_reverse_pipe
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    sh,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err
`ifdef SHIFT_CARRY_EN
  ,
  output logic             co
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [SW-1:0]    s1_sh_q, s1_sh_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s1_ill_q, s1_ill_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             err_q, err_d;

  logic s2_ready, in_fire;

  assign s2_ready = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign in_fire  = in_valid && in_ready;

  // Stage 2 datapath: left ops run through the right core on a reversed operand.
  logic             s1_left, s1_rev, s1_rot, core_fill;
  logic [SW-1:0]    core_sh;
  logic [WIDTH-1:0] a_rev, core_in, core_out, core_out_rev, res;

  assign s1_left   = is_left(s1_op_q);
  assign s1_rev    = (s1_op_q == OP_REV);
  assign s1_rot    = (s1_op_q == OP_ROL) || (s1_op_q == OP_ROR);
  assign core_fill = (s1_op_q == OP_SRA) && s1_a_q[WIDTH-1];
  assign core_sh   = s1_rev ? '0 : s1_sh_q;
  assign core_in   = s1_left ? a_rev : s1_a_q;

  always_comb begin
    a_rev        = '0;
    core_out_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_rev[i]        = s1_a_q[WIDTH-1-i];
      core_out_rev[i] = core_out[WIDTH-1-i];
    end
  end

  shift_right_core #(.WIDTH(WIDTH)) u_core (
    .din    (core_in),
    .sh     (core_sh),
    .rotate (s1_rot),
    .fill   (core_fill),
    .dout   (core_out)
  );

  assign res = s1_ill_q ? '0 : ((s1_left || s1_rev) ? core_out_rev : core_out);

`ifdef SHIFT_CARRY_EN
  // On the reversed operand the bit leaving a left op sits at sh-1, same as a right op.
  logic          co_q, co_d, carry;
  logic [SW-1:0] sh_m1;

  assign sh_m1 = s1_sh_q - SW'(1);
  assign carry = !s1_ill_q && !s1_rev && (s1_sh_q != '0) && core_in[sh_m1];
`endif

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_sh_d     = s1_sh_q;
    s1_op_d     = s1_op_q;
    s1_ill_d    = s1_ill_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    err_d       = err_q;
`ifdef SHIFT_CARRY_EN
    co_d        = co_q;
`endif

    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d        = res;
        err_d      = s1_ill_q;
`ifdef SHIFT_CARRY_EN
        co_d       = carry;
`endif
        s1_valid_d = 1'b0;
      end
    end

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_sh_d    = sh;
      s1_op_d    = op;
      s1_ill_d   = is_illegal(op);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_sh_q     <= '0;
      s1_op_q     <= '0;
      s1_ill_q    <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      err_q       <= 1'b0;
`ifdef SHIFT_CARRY_EN
      co_q        <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_sh_q     <= s1_sh_d;
      s1_op_q     <= s1_op_d;
      s1_ill_q    <= s1_ill_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      err_q       <= err_d;
`ifdef SHIFT_CARRY_EN
      co_q        <= co_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign err       = err_q;
`ifdef SHIFT_CARRY_EN
  assign co        = co_q;
`endif

endmodule

// File: tb/tb_shift_reverse_pipe.sv
// Self-checking bench for shift_reverse_pipe at WIDTH=8 and WIDTH=32 (co checked when SHIFT_CARRY_EN).
module tb_shift_reverse_pipe;

  typedef struct {
    logic [7:0] a;
    logic [2:0] sh;
    logic [2:0] op;
    logic [7:0] exp_y;
    logic       exp_err;
    logic       exp_co;
  } vec_t;

  typedef struct {
    logic [63:0] y;
    logic        err;
    logic        co;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, err8;
  logic [7:0] a8, y8;
  logic [2:0] sh8, op8;
`ifdef SHIFT_CARRY_EN
  logic       co8;
`endif

  logic        v32_in_valid, v32_in_ready, v32_out_valid, v32_out_ready, v32_err;
  logic [31:0] v32_a, v32_y;
  logic [4:0]  v32_sh;
  logic [2:0]  v32_op;
`ifdef SHIFT_CARRY_EN
  logic        v32_co;
`endif

  shift_reverse_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a8), .sh(sh8), .op(op8), .out_valid(out_valid), .out_ready(out_ready),
    .y(y8), .err(err8)
`ifdef SHIFT_CARRY_EN
    , .co(co8)
`endif
  );

  shift_reverse_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32_in_valid), .in_ready(v32_in_ready),
    .a(v32_a), .sh(v32_sh), .op(v32_op), .out_valid(v32_out_valid), .out_ready(v32_out_ready),
    .y(v32_y), .err(v32_err)
`ifdef SHIFT_CARRY_EN
    , .co(v32_co)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  res_t sb[$];
  int n_acc;
  logic prev_stall;
  logic [7:0] prev_y;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference computed directly from the operation definitions.
  function automatic res_t model(input int w, input logic [63:0] a_in, input int s, input logic [2:0] o);
    res_t r;
    logic [63:0] mask, av;
    mask  = (64'd1 << w) - 64'd1;
    av    = a_in & mask;
    r.y   = '0;
    r.err = 1'b0;
    r.co  = 1'b0;
    case (o)
      3'd0: begin r.y = (av << s) & mask; if (s > 0) r.co = av[w-s]; end
      3'd1: begin r.y = av >> s; if (s > 0) r.co = av[s-1]; end
      3'd2: begin
        r.y = av >> s;
        if (av[w-1]) r.y = r.y | (mask & ~(mask >> s));
        if (s > 0) r.co = av[s-1];
      end
      3'd3: begin r.y = (s > 0) ? (((av << s) | (av >> (w-s))) & mask) : av; if (s > 0) r.co = av[w-s]; end
      3'd4: begin r.y = (s > 0) ? (((av >> s) | (av << (w-s))) & mask) : av; if (s > 0) r.co = av[s-1]; end
      3'd5: for (int i = 0; i < w; i++) r.y[i] = av[w-1-i];
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // One clock of the 8-bit DUT with scoreboard tracking; inputs are already driven.
  task automatic step();
    res_t e;
    #1;
    if (prev_stall) begin
      chk("stall_valid_held", 64'(out_valid), 64'd1);
      chk("stall_y_held", 64'(y8), 64'(prev_y));
    end
    prev_stall = out_valid && !out_ready;
    prev_y     = y8;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'(y8), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("sb_y", 64'(y8), e.y);
        chk("sb_err", 64'(err8), 64'(e.err));
`ifdef SHIFT_CARRY_EN
        chk("sb_co", 64'(co8), 64'(e.co));
`endif
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(model(8, 64'(a8), int'(sh8), op8));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    a8 = v.a; sh8 = v.sh; op8 = v.op; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd2);
    chk({name, "_y"}, 64'(y8), 64'(v.exp_y));
    chk({name, "_err"}, 64'(err8), 64'(v.exp_err));
`ifdef SHIFT_CARRY_EN
    chk({name, "_co"}, 64'(co8), 64'(v.exp_co));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input logic [31:0] av, input logic [4:0] s, input logic [2:0] o,
                       input logic [31:0] exp_y, input logic exp_co, input string name);
    int lat;
    res_t m;
    v32_a = av; v32_sh = s; v32_op = o; v32_in_valid = 1'b1;
    @(posedge clk);
    #1;
    v32_in_valid = 1'b0;
    lat = 1;
    while (!v32_out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    m = model(32, 64'(av), int'(s), o);
    chk({name, "_latency"}, 64'(lat), 64'd2);
    chk({name, "_y"}, 64'(v32_y), 64'(exp_y));
    chk({name, "_y_model"}, 64'(v32_y), m.y);
    chk({name, "_err"}, 64'(v32_err), 64'd0);
`ifdef SHIFT_CARRY_EN
    chk({name, "_co"}, 64'(v32_co), 64'(exp_co));
`endif
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];
  logic [7:0] bp_a[3];
  int guard;

  initial begin
    tbl[0]  = '{8'h0F, 3'd0, 3'b101, 8'hF0, 1'b0, 1'b0};
    tbl[1]  = '{8'h90, 3'd3, 3'b010, 8'hF2, 1'b0, 1'b0};
    tbl[2]  = '{8'h90, 3'd3, 3'b001, 8'h12, 1'b0, 1'b0};
    tbl[3]  = '{8'h81, 3'd1, 3'b011, 8'h03, 1'b0, 1'b1};
    tbl[4]  = '{8'h81, 3'd1, 3'b100, 8'hC0, 1'b0, 1'b1};
    tbl[5]  = '{8'hFF, 3'd5, 3'b111, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{8'h01, 3'd7, 3'b000, 8'h80, 1'b0, 1'b0};
    tbl[7]  = '{8'hC3, 3'd0, 3'b000, 8'hC3, 1'b0, 1'b0};
    tbl[8]  = '{8'h7F, 3'd7, 3'b010, 8'h00, 1'b0, 1'b1};
    tbl[9]  = '{8'h01, 3'd0, 3'b100, 8'h01, 1'b0, 1'b0};
    tbl[10] = '{8'h55, 3'd2, 3'b110, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{8'hFF, 3'd4, 3'b000, 8'hF0, 1'b0, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a8 = '0; sh8 = '0; op8 = '0;
    v32_in_valid = 1'b0; v32_out_ready = 1'b1; v32_a = '0; v32_sh = '0; v32_op = '0;
    prev_stall = 1'b0; prev_y = '0; n_acc = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y8), 64'd0);
    chk("rst_err", 64'(err8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: three back-to-back operands against a stalled consumer.
    bp_a[0] = 8'h11; bp_a[1] = 8'h22; bp_a[2] = 8'h33;
    n_acc = 0; out_ready = 1'b0; op8 = 3'b001; sh8 = 3'd1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (n_acc < 3);
      a8 = bp_a[(n_acc < 3) ? n_acc : 2];
      step();
    end
    chk("bp_accepted", 64'(n_acc), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_y_first", 64'(y8), 64'h08);
    out_ready = 1'b1;
    guard = 0;
    while ((sb.size() != 0 || n_acc < 3) && guard < 20) begin
      in_valid = (n_acc < 3);
      a8 = bp_a[(n_acc < 3) ? n_acc : 2];
      step();
      guard++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 64'(n_acc), 64'd3);
    chk("bp_drained", 64'(sb.size()), 64'd0);
    step();

    // Randomised traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a8  = 8'($urandom);
      sh8 = 3'($urandom_range(0, 7));
      op8 = 3'($urandom_range(0, 7));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      step();
      guard++;
    end
    chk("rand_drained", 64'(sb.size()), 64'd0);

    // Reset with two items in flight.
    out_ready = 1'b0; op8 = 3'b101; n_acc = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = (n_acc < 2);
      a8 = 8'hA5;
      step();
    end
    in_valid = 1'b0;
    chk("mid_out_valid_pre", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_y", 64'(y8), 64'd0);
    chk("mid_rst_err", 64'(err8), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef SHIFT_CARRY_EN
    chk("mid_rst_co", 64'(co8), 64'd0);
`endif
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end

    run32(32'h0000FFFF, 5'd31, 3'b101, 32'hFFFF0000, 1'b0, "w32_rev");
    run32(32'h80000003, 5'd31, 3'b011, 32'hC0000001, 1'b1, "w32_rol");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
